// File: rtl/ft_pkg.sv
// Shared types and helpers for the fault-tolerant core's register-file copy engine.
package ft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ft_copy_state_e;

  // Width of the GPR file index: RV32E has 16 registers, RV32I has 32.
  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 32'd4 : 32'd5;
  endfunction

endpackage

// File: rtl/ft_rf_copy_engine.sv
// Streams GPRs x1..x(NUM_WORDS-1) from a source read port into a destination
// write port, one register per cycle, through a single write pipeline stage.
module ft_rf_copy_engine
  import ft_pkg::*;
#(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4:0]            src_raddr_o,
  input  logic [DATA_WIDTH-1:0] src_rdata_i,
  output logic [4:0]            dst_waddr_o,
  output logic [DATA_WIDTH-1:0] dst_wdata_o,
  output logic                  dst_we_o
);

  localparam int unsigned ADDR_WIDTH = rf_addr_width(RV32E);
  localparam int unsigned NUM_WORDS  = 32'd1 << ADDR_WIDTH;
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_WORDS - 32'd1);

  ft_copy_state_e        state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COPY;
          idx_d   = 5'd1;
        end else begin
          idx_d   = 5'd0;
        end
      end
      COPY: begin
        wdata_d = src_rdata_i;
        waddr_d = idx_q;
        we_d    = 1'b1;
        // Park idx at 0 after the last read instead of letting it wrap.
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = 5'd0;
        end else begin
          idx_d   = idx_q + 5'd1;
        end
      end
      DRAIN: begin
        we_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
        we_d    = 1'b0;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
      idx_d   = 5'd0;
      we_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Outputs are flops or decodes of flops only; inputs never reach them combinationally.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign src_raddr_o = (state_q == COPY) ? idx_q : 5'd0;
  assign dst_waddr_o = waddr_q;
  assign dst_wdata_o = wdata_q;
  assign dst_we_o    = we_q;

endmodule

// File: tb/tb_ft_rf_copy_engine.sv
// Directed bench: an RV32I and an RV32E copy engine, each between two bench GPR files.
module tb_ft_rf_copy_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0, busy_a, done_a, we_a;
  logic [4:0]  raddr_a, waddr_a;
  logic [31:0] rdata_a, wdata_a;
  logic        start_b = 1'b0, abort_b = 1'b0, busy_b, done_b, we_b;
  logic [4:0]  raddr_b, waddr_b;
  logic [31:0] rdata_b, wdata_b;

  logic [31:0] src_a [32];
  logic [31:0] dst_a [32];
  logic [31:0] src_b [32];
  logic [31:0] dst_b [32];
  int          wr_cnt_a = 0, wr_cnt_b = 0;
  int          init_a = 0, init_b = 0;

  int checks = 0;
  int failures = 0;
  bit sel_b = 1'b0;

  ft_rf_copy_engine #(.RV32E(1'b0), .DATA_WIDTH(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .busy_o(busy_a), .done_o(done_a), .src_raddr_o(raddr_a), .src_rdata_i(rdata_a),
    .dst_waddr_o(waddr_a), .dst_wdata_o(wdata_a), .dst_we_o(we_a)
  );

  ft_rf_copy_engine #(.RV32E(1'b1), .DATA_WIDTH(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .busy_o(busy_b), .done_o(done_b), .src_raddr_o(raddr_b), .src_rdata_i(rdata_b),
    .dst_waddr_o(waddr_b), .dst_wdata_o(wdata_b), .dst_we_o(we_b)
  );

  assign rdata_a = src_a[raddr_a];
  assign rdata_b = src_b[raddr_b];

  // Destination GPR files: bench-initialised, then written only by the engines.
  always @(posedge clk) begin
    if (init_a != 0) begin
      for (int i = 0; i < 32; i++) dst_a[i] <= (init_a == 2) ? (32'hDEAD_0000 + i) : 32'h0;
    end else if (we_a) begin
      dst_a[waddr_a] <= wdata_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (init_b != 0) begin
      for (int i = 0; i < 32; i++) dst_b[i] <= 32'h0;
    end else if (we_b) begin
      dst_b[waddr_b] <= wdata_b;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  logic        obs_we, obs_busy, obs_done;
  logic [4:0]  obs_waddr, obs_raddr;
  logic [31:0] obs_wdata;
  assign obs_we    = sel_b ? we_b    : we_a;
  assign obs_busy  = sel_b ? busy_b  : busy_a;
  assign obs_done  = sel_b ? done_b  : done_a;
  assign obs_waddr = sel_b ? waddr_b : waddr_a;
  assign obs_raddr = sel_b ? raddr_b : raddr_a;
  assign obs_wdata = sel_b ? wdata_b : wdata_a;

  function automatic logic [31:0] get_dst(input int i);
    return sel_b ? dst_b[i] : dst_a[i];
  endfunction

  task automatic set_start(input logic v);
    start_a = sel_b ? 1'b0 : v;
    start_b = sel_b ? v : 1'b0;
  endtask

  task automatic load_src(input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      if (sel_b) src_b[i] = base + i;
      else       src_a[i] = base + i;
    end
  endtask

  task automatic init_dst(input int mode);
    if (sel_b) init_b = mode;
    else       init_a = mode;
    @(negedge clk);
    init_a = 0;
    init_b = 0;
  endtask

  // Full copy on the selected engine with start pulsed before E0; observe after each E_k.
  task automatic run_copy(input int nw, input logic [31:0] base, input string tag);
    int bit4_hits;
    bit4_hits = 0;
    set_start(1'b1);
    for (int k = 0; k <= nw + 2; k++) begin
      @(negedge clk);
      set_start(1'b0);
      checks++;
      if (obs_we !== ((k >= 1) && (k <= nw - 1))) begin
        failures++;
        $display("FAIL %s_we k=%0d: got %b expected %b", tag, k, obs_we, ((k >= 1) && (k <= nw - 1)));
      end
      checks++;
      if (obs_busy !== (k <= nw)) begin
        failures++;
        $display("FAIL %s_busy k=%0d: got %b expected %b", tag, k, obs_busy, (k <= nw));
      end
      checks++;
      if (obs_done !== (k == nw)) begin
        failures++;
        $display("FAIL %s_done k=%0d: got %b expected %b", tag, k, obs_done, (k == nw));
      end
      checks++;
      if (obs_raddr !== ((k <= nw - 2) ? 5'(k + 1) : 5'd0)) begin
        failures++;
        $display("FAIL %s_raddr k=%0d: got %0d expected %0d", tag, k, obs_raddr, ((k <= nw - 2) ? k + 1 : 0));
      end
      if (obs_we === 1'b1) begin
        checks++;
        if (obs_waddr !== 5'(k)) begin
          failures++;
          $display("FAIL %s_waddr k=%0d: got %0d expected %0d", tag, k, obs_waddr, k);
        end
        checks++;
        if (obs_wdata !== base + 32'(k)) begin
          failures++;
          $display("FAIL %s_wdata k=%0d: got %h expected %h", tag, k, obs_wdata, base + 32'(k));
        end
      end
      if (obs_raddr[4] || obs_waddr[4]) bit4_hits++;
    end
    if (nw == 16) begin
      checks++;
      if (bit4_hits != 0) begin
        failures++;
        $display("FAIL %s_addr_bit4: got %0d cycles with bit4 set, expected 0", tag, bit4_hits);
      end
    end
    for (int i = 1; i < nw; i++) begin
      checks++;
      if (get_dst(i) !== base + 32'(i)) begin
        failures++;
        $display("FAIL %s_dst_x%0d: got %h expected %h", tag, i, get_dst(i), base + 32'(i));
      end
    end
    checks++;
    if (get_dst(0) !== 32'h0) begin
      failures++;
      $display("FAIL %s_dst_x0: got %h expected 00000000", tag, get_dst(0));
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy_a, done_a, we_a, raddr_a, waddr_a, wdata_a} !== 45'h0) begin
      failures++;
      $display("FAIL reset_a: got %h expected 0", {busy_a, done_a, we_a, raddr_a, waddr_a, wdata_a});
    end
    checks++;
    if ({busy_b, done_b, we_b, raddr_b, waddr_b, wdata_b} !== 45'h0) begin
      failures++;
      $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, we_b, raddr_b, waddr_b, wdata_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_copy();
    sel_b = 1'b0;
    load_src(32'h1000_0000);
    init_dst(1);
    run_copy(32, 32'h1000_0000, "full32");
  endtask

  task automatic test_rv32e();
    sel_b = 1'b1;
    load_src(32'h1000_0000);
    init_dst(1);
    run_copy(16, 32'h1000_0000, "rv32e");
    sel_b = 1'b0;
  endtask

  task automatic test_abort();
    int found, wc, extra_done;
    sel_b = 1'b0;
    found = 0;
    extra_done = 0;
    load_src(32'hA5A5_0000);
    init_dst(2);
    set_start(1'b1);
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      set_start(1'b0);
      if (we_a && waddr_a == 5'd10) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL abort_reach_addr10: got no write to 10 within 40 cycles, expected one");
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if ({we_a, busy_a, done_a} !== 3'b000) begin
      failures++;
      $display("FAIL abort_outputs: got we/busy/done=%b expected 000", {we_a, busy_a, done_a});
    end
    wc = wr_cnt_a;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a || busy_a) extra_done++;
    end
    checks++;
    if (extra_done != 0 || wr_cnt_a != wc) begin
      failures++;
      $display("FAIL abort_quiet: got %0d busy/done cycles, %0d writes, expected 0 and 0", extra_done, wr_cnt_a - wc);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dst_a[i] !== ((i >= 1 && i <= 10) ? 32'hA5A5_0000 + i : 32'hDEAD_0000 + i)) begin
        failures++;
        $display("FAIL abort_dst_x%0d: got %h expected %h", i, dst_a[i],
                 ((i >= 1 && i <= 10) ? 32'hA5A5_0000 + i : 32'hDEAD_0000 + i));
      end
    end
  endtask

  task automatic test_start_held();
    int nwr, ndone, first_done_k, second_done_k, second_start_k;
    sel_b = 1'b0;
    nwr = 0; ndone = 0; first_done_k = -1; second_done_k = -1; second_start_k = -1;
    load_src(32'h3000_0000);
    init_dst(1);
    // start high for edges E0..E39 except a dip at E10, which lands mid-copy.
    for (int k = 0; k <= 75; k++) begin
      start_a = (k < 40) && (k != 10);
      @(negedge clk);
      if (we_a) begin
        nwr++;
        if (first_done_k >= 0 && second_start_k < 0) second_start_k = k;
      end
      if (done_a) begin
        ndone++;
        if (first_done_k < 0) first_done_k = k;
        else second_done_k = k;
      end
    end
    start_a = 1'b0;
    checks++;
    if (first_done_k != 32) begin
      failures++;
      $display("FAIL held_first_done: got k=%0d expected 32", first_done_k);
    end
    checks++;
    if (second_start_k != 35 || waddr_a === 5'bx) begin
      failures++;
      $display("FAIL held_second_start: got k=%0d expected 35", second_start_k);
    end
    checks++;
    if (second_done_k != 66) begin
      failures++;
      $display("FAIL held_second_done: got k=%0d expected 66", second_done_k);
    end
    checks++;
    if (nwr != 62 || ndone != 2) begin
      failures++;
      $display("FAIL held_counts: got writes=%0d dones=%0d expected 62 and 2", nwr, ndone);
    end
  endtask

  task automatic test_start_abort_idle();
    int wc, busy_hits;
    sel_b = 1'b0;
    wc = wr_cnt_a;
    busy_hits = 0;
    start_a = 1'b1;
    abort_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy_a || we_a) busy_hits++;
    end
    start_a = 1'b0;
    abort_a = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_hits != 0 || wr_cnt_a != wc) begin
      failures++;
      $display("FAIL start_abort_idle: got %0d busy cycles, %0d writes, expected 0 and 0", busy_hits, wr_cnt_a - wc);
    end
  endtask

  task automatic test_async_reset();
    int found;
    sel_b = 1'b0;
    found = 0;
    load_src(32'h5000_0000);
    init_dst(1);
    set_start(1'b1);
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      set_start(1'b0);
      if (we_a && waddr_a == 5'd5) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL rst_reach_addr5: got no write to 5 within 40 cycles, expected one");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we_a, busy_a, done_a, waddr_a} !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: got we/busy/done/waddr=%h expected 00", {we_a, busy_a, done_a, waddr_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_src(32'h6000_0000);
    init_dst(1);
    run_copy(32, 32'h6000_0000, "after_rst");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      src_a[i] = 32'h0;
      src_b[i] = 32'h0;
    end
    test_reset();
    test_full_copy();
    test_rv32e();
    test_abort();
    test_start_held();
    test_start_abort_idle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft_rf_copy_engine.md
Name: ft_rf_copy_engine

Overview:
- Sequential copier that streams architectural registers x1..x(NUM_WORDS-1) from a source register file read port into a destination register file write port.
- Used in the FT core for replica resynchronisation and rollback restore: the healthy replica's GPR file is the source, and the recovering replica's GPR file is the destination.
- It is the driver of the GPR write-port interface (waddr/wdata/we), paired with a consumer of one GPR read port (raddr/rdata, combinational read).

Parameters:
- RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4), 0 selects 32 registers (ADDR_WIDTH=5)
- DATA_WIDTH, 32, register data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- start_i  in  1  request a copy; sampled only in IDLE
- abort_i  in  1  cancel the copy in progress; highest priority
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after the last write completes
- src_raddr_o  out  5  source read address; bit 4 is 0 when RV32E=1
- src_rdata_i  in  DATA_WIDTH  source read data, combinational from src_raddr_o
- dst_waddr_o  out  5  destination write address
- dst_wdata_o  out  DATA_WIDTH  destination write data
- dst_we_o  out  1  destination write enable

Behaviour:
- NUM_WORDS = 2**ADDR_WIDTH. Register x0 is never read or written. The engine performs exactly NUM_WORDS-1 writes per copy.
- Reset values: state=IDLE; idx, busy_o, done_o, src_raddr_o, dst_waddr_o, dst_wdata_o and dst_we_o all 0.
- All outputs are flop-driven or decoded from state flops only. No combinational path from any input to any output.
- FSM states: IDLE, COPY, DRAIN, DONE.
- IDLE:
  - src_raddr_o=0.
  - start_i=1 -> COPY, idx<=1.
- COPY:
  - src_raddr_o=idx.
  - At each edge: wdata_q<=src_rdata_i, waddr_q<=idx, we_q<=1, idx<=idx+1.
  - When idx==NUM_WORDS-1 at the edge -> DRAIN. idx never wraps to 0.
- DRAIN:
  - src_raddr_o=0.
  - The last write is presented during this state.
  - Next edge: we_q<=0, go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
- Timing, with start_i sampled at edge E0:
  - dst_we_o is high in the cycles following E1..E(NUM_WORDS-1), with dst_waddr_o = 1,2,...,NUM_WORDS-1 in order.
  - Each write carries src_rdata_i as sampled one cycle earlier at the same address.
  - done_o is high in the cycle after E(NUM_WORDS).
  - Total latency from start to done: NUM_WORDS+1 edges (33 for RV32I, 17 for RV32E).
- dst_we_o is exactly we_q. dst_waddr_o and dst_wdata_o hold their last values when we_q=0, and are don't-care for the destination.
- start_i while busy_o=1 is ignored. There is no queuing, and idx does not restart.
- abort_i=1 in any state -> IDLE at the next edge:
  - we_q<=0 and idx<=0.
  - No done_o pulse.
  - Writes already issued are not undone.
- start_i and abort_i both high in IDLE: abort wins and the engine stays IDLE.
- Asynchronous rst_n assertion mid-copy forces all reset values immediately. dst_we_o drops without waiting for a clock edge.
- Source contents changing mid-copy: each register is copied with its value at its own read cycle. No snapshot semantics.

Decomposition:
- Shared package ft_pkg:
  - ft_copy_state_e enum (IDLE, COPY, DRAIN, DONE)
  - function rf_addr_width(rv32e) returning 4 or 5
- No sub-module. It is a single FSM plus a counter and a one-entry write pipeline register. A GPR-file instance is used only in the bench.

Test Plan:
- Full copy: source x1..x31 = 32'h1000_0000+i, destination initially zero, pulse start_i once -> 31 writes, addresses 1..31 in consecutive cycles; destination x1..x31 matches the source; x0 stays 0; done_o is a single pulse 33 edges after start; busy_o is high from E0 until done clears.
- RV32E=1: same stimulus with source x1..x15 loaded -> 15 writes to addresses 1..15; dst_waddr_o[4]=0 always; done_o at edge 17; bit 4 of src_raddr_o never set.
- Abort mid-copy: assert abort_i when dst_waddr_o=10 -> dst_we_o is 0 the next cycle; no done_o; destination x1..x10 are copied and x11..x31 are unchanged; busy_o=0.
- start_i held high for 40 cycles and re-pulsed during COPY -> exactly one copy (31 writes), then a second copy begins because start_i is still high in IDLE after DONE; the first done_o precedes the second sequence.
- start_i and abort_i high together in IDLE -> busy_o stays 0 and no writes occur.
- rst_n pulled low asynchronously at dst_waddr_o=5 -> dst_we_o=0, busy_o=0 and done_o=0 immediately, before the next clk edge; after release, a new start performs a full 31-write copy from address 1.
